// File: rtl/tblights_sched.sv
// tblights_sched: front-end controller for the Thunderbird taillight sequencer.
// Conditions the raw lever/hazard switches, arbitrates LEFT/RIGHT/HAZ requests,
// drives the one-hot L/R/H mode lines and a step pulse every DIV cycles.
// A started flash sequence always completes before the mode changes, except
// that a hazard request preempts LEFT/RIGHT immediately.
// Build option: define TBLIGHTS_DEBOUNCE_EN to enable the DEB-sample debounce;
// otherwise each switch passes through a single synchronising flop.
module tblights_sched #(
  parameter int unsigned DIV     = 4,
  parameter int unsigned DEB     = 3,
  parameter int unsigned SEQ_LEN = 4
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         left_sw,
  input  logic                         right_sw,
  input  logic                         haz_sw,
  output logic                         L,
  output logic                         R,
  output logic                         H,
  output logic                         step,
  output logic [$clog2(SEQ_LEN)-1:0]   phase,
  output logic                         busy
);

  localparam int unsigned PW  = $clog2(SEQ_LEN);
  localparam int unsigned PRW = $clog2(DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2,
    S_HAZ   = 2'd3
  } state_t;

  // bit 0 = left, bit 1 = right, bit 2 = hazard
  logic [2:0] w_raw;
  logic [2:0] r_deb;

  assign w_raw = {haz_sw, right_sw, left_sw};

`ifdef TBLIGHTS_DEBOUNCE_EN
  localparam int unsigned CW = (DEB > 1) ? $clog2(DEB) : 1;

  logic [2:0][CW-1:0] r_cnt;

  // Flip a debounced value after DEB consecutive disagreeing samples.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_raw[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEB - 1)) begin
          r_deb[i] <= ~r_deb[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  logic w_unused_deb;
  assign w_unused_deb = (DEB == 0);

  // Single-flop sampling of the raw switches.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_deb <= '0;
    end else begin
      r_deb <= w_raw;
    end
  end
`endif

  state_t           r_state, w_state_nxt;
  logic [PRW-1:0]   r_presc, w_presc_nxt;
  logic [PW-1:0]    r_phase, w_phase_nxt;
  state_t           w_req;
  logic             w_step;
  logic             w_last;

  // Request priority: hazard (or both levers) over single lever over idle.
  always_comb begin
    w_req = S_IDLE;
    if (r_deb[2] || (r_deb[0] && r_deb[1])) begin
      w_req = S_HAZ;
    end else if (r_deb[0]) begin
      w_req = S_LEFT;
    end else if (r_deb[1]) begin
      w_req = S_RIGHT;
    end
  end

  assign w_step = (r_state != S_IDLE) && (r_presc == PRW'(DIV - 1));
  assign w_last = w_step && (r_phase == PW'(SEQ_LEN - 1));

  // State, prescaler and phase registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next-state: mode changes only from IDLE, at end of sequence, or on hazard preempt.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = w_step ? '0 : r_presc + PRW'(1);
    w_phase_nxt = w_step ? r_phase + PW'(1) : r_phase;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = w_req;
        w_presc_nxt = '0;
        w_phase_nxt = '0;
      end
      S_LEFT, S_RIGHT: begin
        if (w_req == S_HAZ || w_last) begin
          w_state_nxt = w_req;
          w_presc_nxt = '0;
          w_phase_nxt = '0;
        end
      end
      S_HAZ: begin
        if (w_last) begin
          w_state_nxt = w_req;
          w_presc_nxt = '0;
          w_phase_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_presc_nxt = '0;
        w_phase_nxt = '0;
      end
    endcase
  end

  assign L     = (r_state == S_LEFT);
  assign R     = (r_state == S_RIGHT);
  assign H     = (r_state == S_HAZ);
  assign busy  = (r_state != S_IDLE);
  assign step  = w_step;
  assign phase = r_phase;

endmodule

// File: tb/tb_tblights_sched.sv
// Bench for tblights_sched: randomized switch stimulus against a time-in-mode
// reference model, plus directed scenarios with literal expectations.
module tb_tblights_sched;

  localparam int DIV     = 4;
  localparam int DEB     = 3;
  localparam int SEQ_LEN = 4;
`ifdef TBLIGHTS_DEBOUNCE_EN
  localparam int LAT = DEB + 1;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       left_sw = 1'b0;
  logic       right_sw = 1'b0;
  logic       haz_sw = 1'b0;
  logic       L, R, H, step, busy;
  logic [1:0] phase;

  int n_vec = 0;
  int n_err = 0;

  tblights_sched #(.DIV(DIV), .DEB(DEB), .SEQ_LEN(SEQ_LEN)) dut (
    .clk(clk), .clear(clear), .left_sw(left_sw), .right_sw(right_sw),
    .haz_sw(haz_sw), .L(L), .R(R), .H(H), .step(step), .phase(phase),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=left 2=right 3=haz; t = cycles since mode entry.
  int m_mode = 0;
  int m_t = 0;
  int m_deb[3] = '{0, 0, 0};
  int m_run[3] = '{0, 0, 0};

  function automatic int resolve(input int d0, input int d1, input int d2);
    if (d2 != 0 || (d0 != 0 && d1 != 0)) return 3;
    if (d0 != 0) return 1;
    if (d1 != 0) return 2;
    return 0;
  endfunction

  always @(posedge clk or posedge clear) begin
    int req;
    int raw[3];
    if (clear) begin
      m_mode = 0;
      m_t = 0;
      for (int i = 0; i < 3; i++) begin
        m_deb[i] = 0;
        m_run[i] = 0;
      end
    end else begin
      req = resolve(m_deb[0], m_deb[1], m_deb[2]);
      if (m_mode == 0) begin
        m_mode = req;
        m_t = 0;
      end else if (m_mode != 3 && req == 3) begin
        m_mode = 3;
        m_t = 0;
      end else if (m_t == DIV * SEQ_LEN - 1) begin
        m_mode = req;
        m_t = 0;
      end else begin
        m_t++;
      end
      raw[0] = int'(left_sw);
      raw[1] = int'(right_sw);
      raw[2] = int'(haz_sw);
      for (int i = 0; i < 3; i++) begin
`ifdef TBLIGHTS_DEBOUNCE_EN
        if (raw[i] != m_deb[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] >= DEB) begin
          m_deb[i] = raw[i];
          m_run[i] = 0;
        end
`else
        m_deb[i] = raw[i];
`endif
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!clear) begin
      chk("model_L", int'(L), int'(m_mode == 1));
      chk("model_R", int'(R), int'(m_mode == 2));
      chk("model_H", int'(H), int'(m_mode == 3));
      chk("model_busy", int'(busy), int'(m_mode != 0));
      chk("model_step", int'(step), int'(m_mode != 0 && (m_t % DIV) == DIV - 1));
      chk("model_phase", int'(phase), (m_t / DIV) % SEQ_LEN);
    end
  end

  task automatic pulse_clear();
    #2 clear = 1'b1;
    #1;
    chk("clr_L", int'(L), 0);
    chk("clr_H", int'(H), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_phase", int'(phase), 0);
    chk("clr_step", int'(step), 0);
    #1 clear = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hold;
    int sw;
    wait_n(2);
    clear = 1'b0;

    // Reset and left hold
    left_sw = 1'b1;
    wait_n(LAT - 1);
    chk("left_pre_L", int'(L), 0);
    wait_n(1);
    chk("left_L", int'(L), 1);
    chk("left_phase0", int'(phase), 0);
    chk("left_busy", int'(busy), 1);
    wait_n(DIV - 1);
    chk("left_step1", int'(step), 1);
    chk("left_step1_phase", int'(phase), 0);
    wait_n(1);
    chk("left_step1_off", int'(step), 0);
    chk("left_phase1", int'(phase), 1);
    wait_n(DIV - 1);
    chk("left_step2_phase", int'(phase), 1);
    chk("left_step2", int'(step), 1);
    pulse_clear();
    wait_n(LAT - 1);
    chk("relock_pre_L", int'(L), 0);
    wait_n(1);
    chk("relock_L", int'(L), 1);

    // Release mid-sequence: full sequence completes, then idle
    left_sw = 1'b0;
    wait_n(DIV * SEQ_LEN - 2);
    chk("release_still_L", int'(L), 1);
    wait_n(40);
    chk("release_idle", int'(busy), 0);

`ifdef TBLIGHTS_DEBOUNCE_EN
    // Glitch shorter than DEB is rejected
    left_sw = 1'b1;
    wait_n(2);
    left_sw = 1'b0;
    wait_n(6);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_L", int'(L), 0);
`endif

    // Both levers resolve to hazard
    left_sw = 1'b1;
    right_sw = 1'b1;
    wait_n(LAT);
    chk("both_H", int'(H), 1);
    chk("both_L", int'(L), 0);
    chk("both_R", int'(R), 0);
    left_sw = 1'b0;
    right_sw = 1'b0;
    wait_n(40);
    chk("both_idle", int'(busy), 0);

    // Hazard preempts LEFT at phase 2
    left_sw = 1'b1;
    wait_n(LAT);
    chk("pre_L", int'(L), 1);
    wait_n(2 * DIV);
    chk("pre_phase2", int'(phase), 2);
    haz_sw = 1'b1;
    wait_n(LAT - 1);
    chk("pre_wait_L", int'(L), 1);
    wait_n(1);
    chk("pre_H", int'(H), 1);
    chk("pre_Loff", int'(L), 0);
    chk("pre_phase0", int'(phase), 0);
    wait_n(DIV - 1);
    chk("pre_first_step", int'(step), 1);
    haz_sw = 1'b0;
    left_sw = 1'b0;
    wait_n(40);
    chk("pre_idle", int'(busy), 0);

    // Randomized phase
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        sw = int'($urandom_range(0, 3));
        left_sw  = sw[0];
        right_sw = sw[1];
        haz_sw   = ($urandom_range(0, 5) == 0);
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                           : int'($urandom_range(4, 40));
      end else begin
        hold--;
      end
      if ($urandom_range(0, 599) == 0) pulse_clear();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
